mb_frame_writer: RTL

- Write-side counterpart of the macroblock scan-address generator.
- Accepts reconstructed 4-pixel words in macroblock scan order: 16x16 MBs raster across the frame; inside each MB, row by row, 4-pixel columns left to right.
- Converts each word's scan position to a raster linear word address and issues single-word writes to frame memory.
- Sits between the reconstruction path and frame memory. One output register stage absorbs memory backpressure.

---
 rtl/h264_pkg.sv | 27 ++
 rtl/mb_scan_counter.sv | 59 +++++
 rtl/mb_frame_writer.sv | 106 ++++++++++
 3 files changed

// File: rtl/h264_pkg.sv
// Shared definitions for the macroblock read/write address path.
//   MACRODIM_DEF / PIXW_DEF : default macroblock edge and pixel depth
//   pix_word_t              : one 4-pixel word, leftmost pixel in the LSBs
//   wr_state_t              : frame-writer FSM states
//   mb_word_addr()          : raster linear word address of pixel (x, y)
package h264_pkg;

    localparam int MACRODIM_DEF = 16;
    localparam int PIXW_DEF     = 8;

    typedef logic [4*PIXW_DEF-1:0] pix_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } wr_state_t;

    // Four pixels per word, so a row holds width/4 words.
    function automatic logic [31:0] mb_word_addr(input logic [31:0] x,
                                                 input logic [31:0] y,
                                                 input logic [31:0] width);
        return y * (width >> 2) + (x >> 2);
    endfunction

endpackage

// File: rtl/mb_scan_counter.sv
// Macroblock scan-position counter.
// Walks 4-pixel words in MB scan order: MBs raster across the frame, and
// inside each MB row by row, words left to right.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart at (0,0)
//   advance   : step to the next word position
//   x, y      : current pixel position of the word
//   last      : current position is the final word of the frame
module mb_scan_counter #(
    parameter int MACRODIM  = 16,
    parameter int IMGWIDTH  = 48,
    parameter int IMGHEIGHT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        last
);

    logic [31:0] xbase_reg;
    logic [31:0] ybase_reg;
    logic [31:0] xcount_reg;
    logic [31:0] ycount_reg;

    assign x    = xbase_reg + xcount_reg;
    assign y    = ybase_reg + ycount_reg;
    assign last = (x == 32'(IMGWIDTH - 4)) && (y == 32'(IMGHEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            xbase_reg  <= '0;
            ybase_reg  <= '0;
            xcount_reg <= '0;
            ycount_reg <= '0;
        end else if (advance) begin
            if (xcount_reg == 32'(MACRODIM - 4)) begin
                xcount_reg <= '0;
                if (ycount_reg == 32'(MACRODIM - 1)) begin
                    ycount_reg <= '0;
                    if (x == 32'(IMGWIDTH - 4)) begin
                        // End of an MB row; the final MB wraps the frame to (0,0).
                        xbase_reg <= '0;
                        ybase_reg <= last ? '0 : ybase_reg + 32'(MACRODIM);
                    end else begin
                        xbase_reg <= xbase_reg + 32'(MACRODIM);
                    end
                end else begin
                    ycount_reg <= ycount_reg + 32'd1;
                end
            end else begin
                xcount_reg <= xcount_reg + 32'd4;
            end
        end
    end

endmodule

// File: rtl/mb_frame_writer.sv
// Frame writer: takes reconstructed 4-pixel words in macroblock scan order
// and issues single-word raster-address writes to frame memory through one
// output register stage.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a frame (only honoured in IDLE)
//   in_valid/in_ready   : input word handshake, in_data = 4 pixels
//   mem_we/mem_ready    : memory write handshake, mem_addr/mem_wdata held
//                         stable until accepted
//   busy                : frame in progress (RUN or FLUSH)
//   done                : one-cycle pulse when the last write has completed
//   x, y                : scan position of the next word to be accepted
module mb_frame_writer
    import h264_pkg::*;
#(
    parameter int MACRODIM  = MACRODIM_DEF,
    parameter int IMGWIDTH  = 48,
    parameter int IMGHEIGHT = 48,
    parameter int PIXW      = PIXW_DEF,
    parameter int ADDR_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*PIXW-1:0]   in_data,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [4*PIXW-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic [31:0]         x,
    output logic [31:0]         y
);

    wr_state_t           state_reg;
    wr_state_t           state_next;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [4*PIXW-1:0]   mem_wdata_reg;

    logic                accept;
    logic                mem_fire;
    logic                scan_clear;
    logic                scan_last;
    logic [ADDR_W-1:0]   word_addr;

    mb_scan_counter #(
        .MACRODIM  (MACRODIM),
        .IMGWIDTH  (IMGWIDTH),
        .IMGHEIGHT (IMGHEIGHT)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (scan_clear),
        .advance (accept),
        .x       (x),
        .y       (y),
        .last    (scan_last)
    );

    assign mem_fire   = mem_we_reg & mem_ready;
    // One-entry buffer: a new word may enter whenever the current one leaves.
    assign in_ready   = (state_reg == RUN) & (~mem_we_reg | mem_ready);
    assign accept     = in_valid & in_ready;
    assign scan_clear = (state_reg == IDLE) & start;
    assign word_addr  = ADDR_W'(mb_word_addr(x, y, 32'(IMGWIDTH)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)                state_next = RUN;
            RUN:     if (accept && scan_last)  state_next = FLUSH;
            FLUSH:   if (mem_fire)             state_next = DONE;
            DONE:                              state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Reload also covers the case where the old word leaves this cycle.
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= word_addr;
                mem_wdata_reg <= in_data;
            end else if (mem_fire) begin
                mem_we_reg <= 1'b0;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg == RUN) || (state_reg == FLUSH);
    assign done      = (state_reg == DONE);

endmodule
